// File: rtl/sample_rle_encoder_pkg.sv
// Shared constants for the sample run-length encoder: FSM encoding and sizing helpers.
package sample_rle_encoder_pkg;

   typedef enum logic [1:0] {
      INIT   = 2'd0,
      SINGLE = 2'd1,
      RUN    = 2'd2
   } state_t;

   // Width of a counter able to hold 0..depth inclusive.
   function automatic int unsigned level_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/sample_rle_encoder_if.sv
// Sample-in / encoded-word-out bundle of the RLE encoder, including flush handshake and status.
interface sample_rle_encoder_if
   import sample_rle_encoder_pkg::*;
#(
   parameter int unsigned W     = 16,
   parameter int unsigned DEPTH = 4
);
   localparam int unsigned LW = level_width(DEPTH);

   logic [W-1:0]  in_data;
   logic          in_valid;
   logic          in_ready;
   logic          flush;
   logic          flush_ack;
   logic [W-1:0]  out_data;
   logic          out_valid;
   logic          out_ready;
   logic          overflow_error;
   logic [LW-1:0] level;

   modport master (
      output in_data, in_valid, flush, out_ready,
      input  in_ready, flush_ack, out_data, out_valid, overflow_error, level
   );

   modport slave (
      input  in_data, in_valid, flush, out_ready,
      output in_ready, flush_ack, out_data, out_valid, overflow_error, level
   );

endinterface

// File: rtl/sample_fifo2w.sv
// Shift-register FIFO, up to two writes and one read per cycle; slot 0 is the registered head.
module sample_fifo2w
   import sample_rle_encoder_pkg::*;
#(
   parameter int unsigned W     = 16,
   parameter int unsigned DEPTH = 4
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             clear,
   input  logic                             wr0_en,
   input  logic [W-1:0]                     wr0_data,
   input  logic                             wr1_en,
   input  logic [W-1:0]                     wr1_data,
   input  logic                             rd_en,
   output logic [W-1:0]                     head,
   output logic                             head_valid,
   output logic [level_width(DEPTH)-1:0]    level
);
   localparam int unsigned LW = level_width(DEPTH);

   logic [W-1:0]  mem   [DEPTH];
   logic [W-1:0]  mem_n [DEPTH];
   logic [LW-1:0] base;
   logic [LW-1:0] level_n;
   logic          rd_ok;
   logic          wr0_ok;
   logic          wr1_ok;

   assign head = mem[0];

   // Slots at or above the level always hold zero, so an empty FIFO presents zero.
   always_comb begin
      mem_n  = mem;
      base   = level;
      rd_ok  = rd_en && head_valid;
      if (rd_ok) begin
         for (int i = 0; i < int'(DEPTH) - 1; i++) mem_n[i] = mem[i+1];
         mem_n[DEPTH-1] = '0;
         base = level - LW'(1);
      end
      wr0_ok = wr0_en && (base < LW'(DEPTH));
      wr1_ok = wr1_en && wr0_ok && ((base + LW'(1)) < LW'(DEPTH));
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (wr0_ok && (LW'(i) == base))          mem_n[i] = wr0_data;
         if (wr1_ok && (LW'(i) == base + LW'(1))) mem_n[i] = wr1_data;
      end
      level_n = base + LW'(wr0_ok) + LW'(wr1_ok);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
         level      <= '0;
         head_valid <= 1'b0;
      end else if (clear) begin
         for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
         level      <= '0;
         head_valid <= 1'b0;
      end else begin
         mem        <= mem_n;
         level      <= level_n;
         head_valid <= (level_n != '0);
      end
   end

endmodule

// File: rtl/sample_rle_encoder.sv
// Run-length encoder: literal, literal, repeat count; saturated runs emit an all-ones marker.
module sample_rle_encoder
   import sample_rle_encoder_pkg::*;
#(
   parameter int unsigned W     = 16,
   parameter int unsigned DEPTH = 4
) (
   input logic                clk,
   input logic                rst_n,
   input logic                clear,
   sample_rle_encoder_if.slave bus
);
   localparam int unsigned    LW      = level_width(DEPTH);
   localparam logic [W-1:0]   MARKER  = '1;
   localparam logic [W-1:0]   CNT_MAX = {{(W-1){1'b1}}, 1'b0};

   state_t        state, state_n;
   logic [W-1:0]  last, last_n;
   logic [W-1:0]  cntr, cntr_n;
   logic          ack, ack_n;
   logic          ovf, ovf_n;
   logic          wr0, wr1;
   logic [W-1:0]  d0, d1;
   logic [LW-1:0] lvl;
   logic          room1, room2, accept;

   assign room2              = (lvl <= LW'(DEPTH - 2));
   assign room1              = (lvl < LW'(DEPTH));
   assign accept             = bus.in_valid && room2;
   assign bus.in_ready       = room2;
   assign bus.level          = lvl;
   assign bus.flush_ack      = ack;
   assign bus.overflow_error = ovf;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= INIT;
         last  <= '0;
         cntr  <= '0;
         ack   <= 1'b0;
         ovf   <= 1'b0;
      end else if (clear) begin
         state <= INIT;
         last  <= '0;
         cntr  <= '0;
         ack   <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         state <= state_n;
         last  <= last_n;
         cntr  <= cntr_n;
         ack   <= ack_n;
         ovf   <= ovf_n;
      end
   end

   always_comb begin
      state_n = state;
      last_n  = last;
      cntr_n  = cntr;
      ack_n   = 1'b0;
      ovf_n   = ovf;
      wr0     = 1'b0;
      wr1     = 1'b0;
      d0      = '0;
      d1      = '0;
      if (bus.in_valid && !room2) ovf_n = 1'b1;
      if (accept) begin
         last_n = bus.in_data;
         unique case (state)
            INIT: begin
               wr0 = 1'b1; d0 = bus.in_data; state_n = SINGLE;
            end
            SINGLE: begin
               wr0 = 1'b1; d0 = bus.in_data;
               if (bus.in_data == last) begin
                  cntr_n  = '0;
                  state_n = RUN;
               end
            end
            RUN: begin
               if (bus.in_data == last) begin
                  if (cntr == CNT_MAX) begin
                     wr0 = 1'b1; d0 = MARKER; cntr_n = '0;
                  end else begin
                     cntr_n = cntr + W'(1);
                  end
               end else begin
                  wr0 = 1'b1; d0 = cntr;
                  wr1 = 1'b1; d1 = bus.in_data;
                  state_n = SINGLE;
               end
            end
            default: state_n = INIT;
         endcase
      // The ack cycle still sees flush high; ignoring it then keeps the pulse single.
      end else if (bus.flush && !ack) begin
         if (state == RUN) begin
            if (room1) begin
               wr0 = 1'b1; d0 = cntr; state_n = INIT; ack_n = 1'b1;
            end
         end else begin
            state_n = INIT; ack_n = 1'b1;
         end
      end
   end

   sample_fifo2w #(.W(W), .DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (clear),
      .wr0_en     (wr0),
      .wr0_data   (d0),
      .wr1_en     (wr1),
      .wr1_data   (d1),
      .rd_en      (bus.out_valid && bus.out_ready),
      .head       (bus.out_data),
      .head_valid (bus.out_valid),
      .level      (lvl)
   );

endmodule

// File: doc/sample_rle_encoder.md
SAMPLE_RLE_ENCODER -- requirements
Module: sample_rle_encoder

Interface
REQ-001 Parameter W, default 16: sample/word width; legal W >= 2.
REQ-002 Parameter DEPTH, default 4: output FIFO depth in words; power of 2, >= 2.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst_n  in  1  reset; asynchronous, active-low.
REQ-005 clear  in  1  synchronous pipeline clear, same effect as reset.
REQ-006 in_data  in  W  sample word.
REQ-007 in_valid  in  1  sample present; the producer never stalls.
REQ-008 in_ready  out  1  FIFO free space >= 2; combinational from the FIFO level.
REQ-009 flush  in  1  level request to close a pending run; held high until flush_ack.
REQ-010 flush_ack  out  1  one-cycle pulse: flush completed.
REQ-011 out_data  out  W  encoded word, registered FIFO head.
REQ-012 out_valid  out  1  out_data valid.
REQ-013 out_ready  in  1  consumer accepts; a transfer occurs when out_valid && out_ready.
REQ-014 overflow_error  out  1  sticky: a sample was dropped.
REQ-015 level  out  $clog2(DEPTH+1)  current FIFO occupancy.

Function
REQ-016 The block SHALL accept a sample when in_valid && in_ready; on in_valid && !in_ready it SHALL drop the sample, set overflow_error, and leave state, counter and last sample unchanged.
REQ-017 The FSM SHALL have states INIT, SINGLE and RUN, plus registers last[W-1:0] and cntr[W-1:0].
REQ-018 INIT, accepted sample x: push literal x; go to SINGLE.
REQ-019 SINGLE, x != last: push x. SINGLE, x == last: push x; set cntr=0; go to RUN.
REQ-020 RUN, x == last, cntr != 2^W-2: cntr increments; no push.
REQ-021 RUN, x == last, cntr == 2^W-2: push marker all-ones (2^W-1 repeats); set cntr=0; stay in RUN.
REQ-022 RUN, x != last: push cntr, then x, in the same cycle (two writes, count first); go to SINGLE; no gap is required between input samples.
REQ-023 Each accepted sample SHALL update last.
REQ-024 Flush SHALL be acted on only in cycles with no accepted sample; if a sample is accepted, the flush is deferred.
REQ-025 Flush in RUN: when FIFO free space >= 1, push cntr, go to INIT, and pulse flush_ack; otherwise wait.
REQ-026 Flush in INIT or SINGLE: go to INIT and pulse flush_ack with no push.
REQ-027 Latency: a sample accepted in cycle N into an empty FIFO SHALL appear with out_valid=1 in cycle N+1.
REQ-028 The FIFO SHALL take 0, 1 or 2 writes and 0 or 1 read per cycle; a simultaneous read and write SHALL keep level consistent; it SHALL never overwrite or underflow.
REQ-029 The decoder contract SHALL be: literal, literal, count c means the value repeats c more times; each marker means 2^W-1 more repeats.

Reset
REQ-030 On rst_n low or clear high the block SHALL set: state=INIT, cntr=0, last=0, FIFO empty, out_valid=0, out_data=0, flush_ack=0, overflow_error=0, level=0.
REQ-031 clear SHALL take priority over all other inputs in its cycle.
REQ-032 Reset or clear during RUN SHALL discard the pending count; the next sample is emitted as a fresh literal.

Structure
REQ-033 State encodings and the marker constant SHALL live in the shared sampler constants include; W and DEPTH stay per-instance parameters.
REQ-034 The FIFO SHALL be one sub-module, sample_fifo2w (2-write/1-read, parameters W and DEPTH).

Verification
REQ-035 W=16, out_ready=1, samples A,A,A,B -> outputs A, A, 0x0001, B; overflow_error=0.
REQ-036 W=4, A repeated 17 times, then B -> outputs A, A, 0xF, 0x0, B.
REQ-037 W=16, samples A,A,A, then flush -> outputs A, A, 0x0001, with flush_ack pulsed once; next sample A -> literal A.
REQ-038 DEPTH=4, out_ready=0, distinct samples -> in_ready drops after the 3rd (level=3); the 4th is dropped; overflow_error=1; level stays 3.
REQ-039 rst_n pulsed low mid-RUN -> all outputs 0 immediately; next sample C -> single literal C.
REQ-040 Flush and in_valid high in the same cycle in RUN -> the sample is processed first; flush_ack follows in a later cycle; output order is preserved.
